// File: rtl/monitor_pkg.sv
// Shared types and constants for the UART register monitor.
// FSM states, response codes and command-byte field positions.
package monitor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    LEN,
    WRITE,
    RESP,
    READ
  } state_e;

  localparam logic [7:0] RESP_ACK    = 8'hA5;
  localparam logic [7:0] RESP_BAD_ID = 8'hE1;
  localparam logic [7:0] RESP_RO     = 8'hE2;

  localparam int CMD_RW_BIT = 7;
  localparam int CMD_ID_MSB = 6;

endpackage

// File: rtl/monitor_reg_bank.sv
// Register storage with reset image, RO mirror of hw_in and commit port.
// Ports: clk, reset_n, wr_en/wr_id/wr_data commit, hw_in, regs_q, reg_wr.
module monitor_reg_bank
  import monitor_pkg::*;
#(
  parameter int                   NUM_REGS     = 8,
  parameter int                   REG_BYTES    = 4,
  parameter logic [NUM_REGS-1:0]  RO_MASK      = '0,
  parameter logic [NUM_REGS*REG_BYTES*8-1:0]
                                  RESET_VALUES = '0
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            wr_en,
  input  logic [CMD_ID_MSB:0]             wr_id,
  input  logic [REG_BYTES*8-1:0]          wr_data,
  input  logic [NUM_REGS*REG_BYTES*8-1:0] hw_in,
  output logic [NUM_REGS*REG_BYTES*8-1:0] regs_q,
  output logic [NUM_REGS-1:0]             reg_wr
);

  localparam int RB  = REG_BYTES * 8;
  localparam int W   = NUM_REGS * RB;
  localparam int IDW = CMD_ID_MSB + 1;

  logic [W-1:0]        mem_q, mem_d;
  logic [W-1:0]        ro_bits;
  logic [NUM_REGS-1:0] wr_q, wr_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_en && wr_id == IDW'(i) && !RO_MASK[i]) begin
        mem_d[i*RB +: RB] = wr_data;
        wr_d[i]           = 1'b1;
      end
    end
  end

  always_comb begin
    ro_bits = '0;
    for (int i = 0; i < NUM_REGS; i++)
      ro_bits[i*RB +: RB] = {RB{RO_MASK[i]}};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= RESET_VALUES;
      wr_q  <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
    end
  end

  // RO slots are pure wires from hw_in; their storage is never visible.
  assign regs_q = (mem_q & ~ro_bits) | (hw_in & ro_bits);
  assign reg_wr = wr_q;

endmodule

// File: rtl/uart_reg_monitor.sv
// Byte-stream command monitor: cmd/len/payload over UART to a reg bank.
// Ports: UART rts/cts, rx/tx byte strobes, hw_in, regs_q, reg_wr, busy, err_count.
module uart_reg_monitor
  import monitor_pkg::*;
#(
  parameter int                   NUM_REGS       = 8,
  parameter int                   REG_BYTES      = 4,
  parameter logic [NUM_REGS-1:0]  RO_MASK        = '0,
  parameter int                   TIMEOUT_CYCLES = 50000,
  parameter logic [NUM_REGS*REG_BYTES*8-1:0]
                                  RESET_VALUES   = '0
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            uart_rts,
  output logic                            uart_cts,
  input  logic                            rx_valid,
  input  logic [7:0]                      rx_data,
  input  logic                            rx_error,
  output logic                            tx_valid,
  output logic [7:0]                      tx_data,
  input  logic                            tx_ready,
  input  logic [NUM_REGS*REG_BYTES*8-1:0] hw_in,
  output logic [NUM_REGS*REG_BYTES*8-1:0] regs_q,
  output logic [NUM_REGS-1:0]             reg_wr,
  output logic                            busy,
  output logic [7:0]                      err_count
);

  localparam int RB  = REG_BYTES * 8;
  localparam int IDW = CMD_ID_MSB + 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  state_e          state_q, state_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      idx_q, idx_d;
  logic [RB-1:0]   shadow_q, shadow_d;
  logic [RB-1:0]   snap_q, snap_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            cts_q, cts_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [7:0]      err_q, err_d;

  logic [IDW-1:0]  id;
  logic            is_wr;
  logic            active;
  logic            rx_byte;
  logic            abort;
  logic            last;
  logic            go_resp;
  logic            err_ev;
  logic            wr_en;
  logic [RB-1:0]   sel_data;
  logic            sel_ro;
  logic            id_ok;
  logic [7:0]      nxt_byte;

  assign id      = cmd_q[CMD_ID_MSB:0];
  assign is_wr   = cmd_q[CMD_RW_BIT];
  assign active  = state_q inside {CMD, LEN, WRITE};
  assign rx_byte = active && rx_valid && !rx_error;
  assign abort   = active && (rx_error ||
                   (!rx_valid && tmo_q == TW'(TIMEOUT_CYCLES - 1)));
  assign last    = idx_q == len_q - 8'd1;

  monitor_reg_bank #(
    .NUM_REGS     (NUM_REGS),
    .REG_BYTES    (REG_BYTES),
    .RO_MASK      (RO_MASK),
    .RESET_VALUES (RESET_VALUES)
  ) u_bank (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_id   (id),
    .wr_data (shadow_d),
    .hw_in   (hw_in),
    .regs_q  (regs_q),
    .reg_wr  (reg_wr)
  );

  always_comb begin
    sel_data = '0;
    sel_ro   = 1'b0;
    id_ok    = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (id == IDW'(i)) begin
        sel_data = regs_q[i*RB +: RB];
        sel_ro   = RO_MASK[i];
        id_ok    = 1'b1;
      end
    end
  end

  // Bytes past the register width read back as zero.
  always_comb begin
    nxt_byte = '0;
    for (int b = 0; b < REG_BYTES; b++)
      if (idx_q + 8'd1 == 8'(b))
        nxt_byte = snap_q[b*8 +: 8];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      shadow_q   <= '0;
      snap_q     <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      cts_q      <= 1'b1;
      tmo_q      <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      snap_q     <= snap_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      cts_q      <= cts_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (!uart_rts) state_d = CMD;
      CMD:
        if (abort) state_d = IDLE;
        else if (rx_byte) state_d = LEN;
      LEN:
        if (abort) state_d = IDLE;
        else if (rx_byte) begin
          if (is_wr)
            state_d = (rx_data == 8'd0) ? RESP : WRITE;
          else
            state_d = (rx_data == 8'd0) ? IDLE : READ;
        end
      WRITE:
        if (abort) state_d = IDLE;
        else if (rx_byte && last) state_d = RESP;
      RESP:
        if (tx_ready) state_d = IDLE;
      READ:
        if (tx_ready && last) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_d      = cmd_q;
    len_d      = len_q;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    snap_d     = snap_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    go_resp    = 1'b0;
    err_ev     = abort;
    wr_en      = 1'b0;
    unique case (state_q)
      CMD:
        if (rx_byte) cmd_d = rx_data;
      LEN:
        if (rx_byte) begin
          len_d = rx_data;
          idx_d = '0;
          if (is_wr) begin
            // Preload so bytes not sent keep the old value.
            shadow_d = sel_data;
            go_resp  = rx_data == 8'd0;
          end else if (rx_data != 8'd0) begin
            snap_d     = id_ok ? sel_data : '0;
            tx_valid_d = 1'b1;
            tx_data_d  = snap_d[7:0];
          end
        end
      WRITE:
        if (rx_byte) begin
          for (int b = 0; b < REG_BYTES; b++)
            if (idx_q == 8'(b))
              shadow_d[b*8 +: 8] = rx_data;
          idx_d   = idx_q + 8'd1;
          go_resp = last;
        end
      RESP:
        if (tx_ready) tx_valid_d = 1'b0;
      READ:
        if (tx_ready) begin
          if (last) begin
            tx_valid_d = 1'b0;
          end else begin
            idx_d     = idx_q + 8'd1;
            tx_data_d = nxt_byte;
          end
        end
      default: ;
    endcase
    // Commit uses shadow_d so the final byte lands in the same edge.
    if (go_resp) begin
      tx_valid_d = 1'b1;
      if (!id_ok) begin
        tx_data_d = RESP_BAD_ID;
        err_ev    = 1'b1;
      end else if (sel_ro) begin
        tx_data_d = RESP_RO;
        err_ev    = 1'b1;
      end else begin
        tx_data_d = RESP_ACK;
        wr_en     = 1'b1;
      end
    end
  end

  always_comb begin
    cts_d = !(state_d inside {CMD, LEN, WRITE});
    tmo_d = (active && !rx_valid) ? tmo_q + TW'(1) : '0;
    err_d = (err_ev && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  assign uart_cts  = cts_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign busy      = state_q != IDLE;
  assign err_count = err_q;

endmodule

// File: tb/tb_uart_reg_monitor.sv
// Directed bench for uart_reg_monitor: write/read/RO/bad id/timeout/abort.
// Checks every result against hand-computed constants.
module tb_uart_reg_monitor;

  localparam int NR = 8;
  localparam int RBY = 4;
  localparam int W = NR * RBY * 8;
  localparam logic [W-1:0] RV = {192'h0, 32'hAABBCCDD, 32'h01020304};

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         uart_rts = 1'b1;
  logic         uart_cts;
  logic         rx_valid = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_error = 1'b0;
  logic         tx_valid;
  logic [7:0]   tx_data;
  logic         tx_ready = 1'b1;
  logic [W-1:0] hw_in;
  logic [W-1:0] regs_q;
  logic [NR-1:0] reg_wr;
  logic         busy;
  logic [7:0]   err_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] tx_log[$];
  int wr_cnt[NR];

  uart_reg_monitor #(
    .NUM_REGS       (NR),
    .REG_BYTES      (RBY),
    .RO_MASK        (8'h08),
    .TIMEOUT_CYCLES (40),
    .RESET_VALUES   (RV)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .uart_rts  (uart_rts),
    .uart_cts  (uart_cts),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_error  (rx_error),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .hw_in     (hw_in),
    .regs_q    (regs_q),
    .reg_wr    (reg_wr),
    .busy      (busy),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < NR; i++) wr_cnt[i] = 0;

  always @(negedge clk) begin
    if (reset_n && tx_valid && tx_ready) tx_log.push_back(tx_data);
    for (int i = 0; i < NR; i++) if (reg_wr[i]) wr_cnt[i]++;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] slot(input int i);
    return regs_q[i*32 +: 32];
  endfunction

  function automatic logic [63:0] txs(input int base);
    logic [63:0] v = '0;
    for (int i = base; i < tx_log.size(); i++) v = {v[55:0], tx_log[i]};
    return v;
  endfunction

  function automatic int wr_total();
    int s = 0;
    for (int i = 0; i < NR; i++) s += wr_cnt[i];
    return s;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic begin_cmd();
    uart_rts = 1'b0;
    tick(2);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 300) begin
      tick(1);
      n++;
    end
    chk({tag, "_idle"}, 64'(busy), 64'(0));
    tick(2);
  endtask

  int base;
  int wbase;
  int wr2;
  logic [7:0] held;
  logic changed;

  initial begin
    hw_in = '1;
    hw_in[127:96] = 32'hDEADBEEF;
    tick(3);
    chk("rst_cts", 64'(uart_cts), 64'(1));
    chk("rst_txv", 64'(tx_valid), 64'(0));
    chk("rst_txd", 64'(tx_data), 64'h00);
    chk("rst_wr", 64'(reg_wr), 64'h00);
    chk("rst_err", 64'(err_count), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_slot1", 64'(slot(1)), 64'hAABBCCDD);
    chk("rst_slot2", 64'(slot(2)), 64'h0);
    chk("rst_ro3", 64'(slot(3)), 64'hDEADBEEF);
    reset_n = 1'b1;
    tick(2);

    // write reg 2
    base = tx_log.size();
    begin_cmd();
    chk("cts_cmd", 64'(uart_cts), 64'(0));
    send_byte(8'h82);
    send_byte(8'h04);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    uart_rts = 1'b1;
    chk("w2_wr_lat", 64'(reg_wr), 64'h04);
    chk("w2_cts_resp", 64'(uart_cts), 64'(1));
    wait_idle("w2");
    chk("w2_wrcnt", 64'(wr_cnt[2]), 64'(1));
    chk("w2_slot", 64'(slot(2)), 64'h44332211);
    chk("w2_ntx", 64'(tx_log.size() - base), 64'(1));
    chk("w2_tx", txs(base), 64'hA5);

    // read reg 2, len 6, with a stall
    base = tx_log.size();
    begin_cmd();
    send_byte(8'h02);
    send_byte(8'h06);
    uart_rts = 1'b1;
    chk("r2_lat_v", 64'(tx_valid), 64'(1));
    chk("r2_lat_d", 64'(tx_data), 64'h11);
    tick(1);
    tx_ready = 1'b0;
    held = tx_data;
    changed = 1'b0;
    repeat (10) begin
      tick(1);
      if (tx_data !== held || tx_valid !== 1'b1) changed = 1'b1;
    end
    chk("r2_stall", 64'(changed), 64'(0));
    tx_ready = 1'b1;
    wait_idle("r2");
    chk("r2_ntx", 64'(tx_log.size() - base), 64'(6));
    chk("r2_tx", txs(base), 64'h112233440000);

    // RO write then read with hw_in changing mid-read
    base = tx_log.size();
    wbase = wr_total();
    begin_cmd();
    send_byte(8'h83);
    send_byte(8'h01);
    send_byte(8'hFF);
    uart_rts = 1'b1;
    wait_idle("ro_w");
    chk("ro_tx", txs(base), 64'hE2);
    chk("ro_nowr", 64'(wr_total() - wbase), 64'(0));
    chk("ro_err", 64'(err_count), 64'(1));
    chk("ro_slot", 64'(slot(3)), 64'hDEADBEEF);
    base = tx_log.size();
    begin_cmd();
    send_byte(8'h03);
    send_byte(8'h04);
    uart_rts = 1'b1;
    hw_in[127:96] = 32'h12345678;
    wait_idle("ro_r");
    chk("ro_rd", txs(base), 64'hEFBEADDE);

    // bad id, then partial write of reg 1
    base = tx_log.size();
    wbase = wr_total();
    begin_cmd();
    send_byte(8'h8A);
    send_byte(8'h01);
    send_byte(8'h00);
    uart_rts = 1'b1;
    wait_idle("bad");
    chk("bad_tx", txs(base), 64'hE1);
    chk("bad_nowr", 64'(wr_total() - wbase), 64'(0));
    chk("bad_err", 64'(err_count), 64'(2));
    base = tx_log.size();
    begin_cmd();
    send_byte(8'h81);
    send_byte(8'h01);
    send_byte(8'h5A);
    uart_rts = 1'b1;
    wait_idle("part");
    chk("part_tx", txs(base), 64'hA5);
    chk("part_slot", 64'(slot(1)), 64'hAABBCC5A);
    chk("part_wr", 64'(wr_cnt[1]), 64'(1));

    // timeout mid-write
    base = tx_log.size();
    wbase = wr_total();
    begin_cmd();
    send_byte(8'h81);
    send_byte(8'h04);
    send_byte(8'h01);
    uart_rts = 1'b1;
    tick(30);
    chk("to_busy30", 64'(busy), 64'(1));
    wait_idle("to");
    chk("to_err", 64'(err_count), 64'(3));
    chk("to_notx", 64'(tx_log.size() - base), 64'(0));
    chk("to_nowr", 64'(wr_total() - wbase), 64'(0));
    chk("to_slot", 64'(slot(1)), 64'hAABBCC5A);
    base = tx_log.size();
    begin_cmd();
    send_byte(8'h80);
    send_byte(8'h02);
    send_byte(8'h77);
    send_byte(8'h66);
    uart_rts = 1'b1;
    wait_idle("to_next");
    chk("to_next_tx", txs(base), 64'hA5);
    chk("to_next_slot", 64'(slot(0)), 64'h01026677);

    // rx_error in LEN
    base = tx_log.size();
    begin_cmd();
    send_byte(8'h81);
    rx_error = 1'b1;
    tick(1);
    rx_error = 1'b0;
    uart_rts = 1'b1;
    tick(1);
    chk("rxe_busy", 64'(busy), 64'(0));
    chk("rxe_err", 64'(err_count), 64'(4));
    chk("rxe_notx", 64'(tx_log.size() - base), 64'(0));

    // reset mid-write
    wr2 = wr_cnt[2];
    begin_cmd();
    send_byte(8'h82);
    send_byte(8'h04);
    send_byte(8'h99);
    reset_n = 1'b0;
    #1;
    chk("ar_cts", 64'(uart_cts), 64'(1));
    chk("ar_txv", 64'(tx_valid), 64'(0));
    chk("ar_slot2", 64'(slot(2)), 64'h0);
    chk("ar_slot0", 64'(slot(0)), 64'h01020304);
    chk("ar_err", 64'(err_count), 64'(0));
    uart_rts = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(3);
    chk("ar_nowr", 64'(wr_cnt[2] - wr2), 64'(0));

    // error counter saturation (~350 errors)
    uart_rts = 1'b0;
    rx_error = 1'b1;
    tick(700);
    rx_error = 1'b0;
    uart_rts = 1'b1;
    tick(3);
    chk("sat_err", 64'(err_count), 64'(255));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
